wb_arbiter: RTL and testbench

Writeback arbiter that drives the single register-file write port (rd, write_data, wr_en) from two result producers: the in-order ALU pipe and the long-latency unit (load/mul-div). The ALU stream has fixed timing and cannot be back-pressured; long-latency results use a valid/ready handshake and wait in a small FIFO. The block sits between the execute/memory stages and the register file. It serialises writes, filters x0 writes, and raises a stall request when buffered results are starved.

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU stream, long-latency valid/ready stream and register-file write port.
// The master modport is the producer/regfile side; the slave modport is the arbiter.
interface wb_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      alu_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [XLEN-1:0]           alu_data;
    logic                      ll_valid;
    logic                      ll_ready;
    logic [REG_ADDR_WIDTH-1:0] ll_rd;
    logic [XLEN-1:0]           ll_data;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [XLEN-1:0]           wb_data;
    logic                      ll_pending;
    logic                      starve_stall;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
        output ll_ready, wb_en, wb_rd, wb_data, ll_pending, starve_stall
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
        input  ll_ready, wb_en, wb_rd, wb_data, ll_pending, starve_stall
    );
endinterface

// File: rtl/wb_arbiter.sv
// Serialises ALU and buffered long-latency results onto the single regfile write port (1-cycle write latency).
// ALU always wins; long-latency results wait in a small FIFO and ll_ready drops when it is full.
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic          clk,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic [REG_ADDR_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
    logic [XLEN-1:0]           data_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      wb_en_q, wb_en_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]           wb_data_q, wb_data_d;

    logic full, nonempty, push, pop, alu_win;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign nonempty = (count_q != '0);
    // No pop-bypass: readiness depends only on the registered count.
    assign bus.ll_ready = !full && !reset;
    assign push     = bus.ll_valid && bus.ll_ready && (bus.ll_rd != '0);
    assign alu_win  = bus.alu_valid && (bus.alu_rd != '0);
    assign pop      = !alu_win && nonempty;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        starve_d  = starve_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = '0;
        wb_data_d = '0;

        if (alu_win) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = bus.alu_rd;
            wb_data_d = bus.alu_data;
        end else if (pop) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_mem_q[head_q];
            wb_data_d = data_mem_q[head_q];
            head_d    = head_q + PTR_W'(1);
        end

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (pop || !nonempty) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[tail_q]   <= bus.ll_rd;
            data_mem_q[tail_q] <= bus.ll_data;
        end
    end

    assign bus.wb_en        = wb_en_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.ll_pending   = nonempty;
    assign bus.starve_stall = (starve_q == SW'(STARVE_LIMIT));
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk;
    logic reset;

    wb_arbiter_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(RAW)) bus ();

    wb_arbiter #(
        .XLEN(XLEN), .REG_ADDR_WIDTH(RAW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    int              m_starve;
    logic            m_wb_en;
    logic [RAW-1:0]  m_wb_rd;
    logic [XLEN-1:0] m_wb_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_starve  = 0;
        m_wb_en   = 1'b0;
        m_wb_rd   = '0;
        m_wb_data = '0;
    endtask

    task automatic check_outputs();
        check_eq("wb_en",        32'(bus.wb_en),        32'(m_wb_en));
        check_eq("wb_rd",        32'(bus.wb_rd),        32'(m_wb_rd));
        check_eq("wb_data",      bus.wb_data,           m_wb_data);
        check_eq("ll_ready",     32'(bus.ll_ready),     32'(q.size() < DEPTH));
        check_eq("ll_pending",   32'(bus.ll_pending),   32'(q.size() != 0));
        check_eq("starve_stall", 32'(bus.starve_stall), 32'(m_starve == LIMIT));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wb_en"},    32'(bus.wb_en),        32'd0);
        check_eq({tag, "_wb_rd"},    32'(bus.wb_rd),        32'd0);
        check_eq({tag, "_wb_data"},  bus.wb_data,           32'd0);
        check_eq({tag, "_ll_ready"}, 32'(bus.ll_ready),     32'd0);
        check_eq({tag, "_pending"},  32'(bus.ll_pending),   32'd0);
        check_eq({tag, "_starve"},   32'(bus.starve_stall), 32'd0);
    endtask

    // One cycle: check registered outputs, drive new inputs, advance the model by the spec's rules.
    task automatic step(input logic av, input logic [RAW-1:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [RAW-1:0] lrd, input logic [XLEN-1:0] ld);
        bit   accept, alu_w, popped;
        ent_t e;
        @(negedge clk);
        check_outputs();
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.ll_valid  = lv;
        bus.ll_rd     = lrd;
        bus.ll_data   = ld;

        accept = lv && (q.size() < DEPTH);
        alu_w  = av && (ard != 0);
        popped = !alu_w && (q.size() > 0);
        if (popped || q.size() == 0) m_starve = 0;
        else if (m_starve < LIMIT)   m_starve = m_starve + 1;
        if (alu_w) begin
            m_wb_en = 1'b1; m_wb_rd = ard; m_wb_data = ad;
        end else if (popped) begin
            e = q.pop_front();
            m_wb_en = 1'b1; m_wb_rd = e.rd; m_wb_data = e.data;
        end else begin
            m_wb_en = 1'b0; m_wb_rd = '0; m_wb_data = '0;
        end
        if (accept && lrd != 0) begin
            e.rd = lrd; e.data = ld;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    logic [RAW-1:0] r_ard, r_lrd;

    initial begin
        reset         = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ll_valid  = 1'b0;
        bus.ll_rd     = '0;
        bus.ll_data   = '0;
        model_clear();
        #1;
        check_all_zero("reset");
        #20 reset = 1'b0;

        // ALU only
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        idle();
        idle();
        // x0 filtering on both streams
        step(1'b1, 5'd0, 32'h1111_1111, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h2222_2222);
        idle();
        idle();
        // FIFO fill behind a continuous ALU stream, then drain in order
        step(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd7, 32'h7777_0007);
        step(1'b1, 5'd1, 32'hA000_0002, 1'b1, 5'd8, 32'h8888_0008);
        step(1'b1, 5'd1, 32'hA000_0003, 1'b1, 5'd9, 32'h9999_0009);
        step(1'b1, 5'd1, 32'hA000_0004, 1'b0, '0, '0);
        idle();
        idle();
        idle();
        idle();
        // Starvation: one entry held back by continuous ALU writes, then one bubble
        step(1'b1, 5'd2, 32'hB000_0000, 1'b1, 5'd9, 32'h9000_0009);
        for (int i = 1; i <= 6; i++) step(1'b1, 5'd2, 32'hB000_0000 + i, 1'b0, '0, '0);
        idle();
        idle();
        idle();
        // Contention: ALU rd=3 against FIFO head rd=9
        step(1'b1, 5'd4, 32'hC000_0004, 1'b1, 5'd9, 32'hC000_0009);
        step(1'b1, 5'd3, 32'hC000_0003, 1'b0, '0, '0);
        idle();
        idle();
        // Reset mid-operation with two buffered entries and a write in flight
        step(1'b1, 5'd1, 32'hD000_0001, 1'b1, 5'd10, 32'hD000_000A);
        step(1'b1, 5'd1, 32'hD000_0002, 1'b1, 5'd11, 32'hD000_000B);
        @(posedge clk);
        #2;
        check_outputs();
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_clear();
        bus.alu_valid = 1'b0;
        bus.ll_valid  = 1'b0;
        #10 reset = 1'b0;
        idle();
        idle();
        idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r_ard = RAW'($urandom_range(0, 7));
            r_lrd = RAW'($urandom_range(0, 7));
            step(($urandom_range(0, 99) < 70), r_ard, $urandom,
                 ($urandom_range(0, 99) < 50), r_lrd, $urandom);
        end
        for (int i = 0; i < 4; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
